// File: rtl/stats_collector_avlstrm.sv
// Stats stream sink: decodes framed {addr, val} beats into a shadow bank and commits whole frames
// atomically to a live bank read through a 1-cycle CSR port. Optional watchdog: STATS_COLLECTOR_TIMEOUT_EN.
module stats_collector_avlstrm #(
    parameter int unsigned       NUM_REGS     = 64,
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       VAL_W        = 32,
    parameter logic [ADDR_W-1:0] NOTUSED_ADDR = {ADDR_W{1'b1}},
    parameter int unsigned       TIMEOUT      = 1024
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [ADDR_W+VAL_W-1:0] stats_in_data,
    input  logic                    stats_in_valid,
    input  logic                    stats_in_sop,
    input  logic                    stats_in_eop,
    output logic                    stats_in_ready,
    input  logic                    csr_read,
    input  logic [ADDR_W-1:0]       csr_addr,
    output logic [VAL_W-1:0]        csr_readdata,
    output logic                    csr_readdatavalid,
    output logic [31:0]             frame_cnt,
    output logic [31:0]             drop_cnt
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = 32;
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FRAME = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                ready_q, ready_d;
    logic [VAL_W-1:0]    rddata_q, rddata_d;
    logic                rdvalid_q, rdvalid_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [VAL_W-1:0]    live_q   [NUM_REGS];
    logic [VAL_W-1:0]    live_d   [NUM_REGS];
    logic [VAL_W-1:0]    shadow_q [NUM_REGS];
    logic [VAL_W-1:0]    shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;

    logic [ADDR_W-1:0]   beat_addr_c;
    logic [VAL_W-1:0]    beat_val_c;
    logic                accept_c, restart_c, stray_c, proc_c, commit_c, addr_ok_c;
    logic [1:0]          drop_inc;
    logic                frame_inc;
    logic [CNT_W:0]      drop_sum;

`ifdef STATS_COLLECTOR_TIMEOUT_EN
    logic [31:0]         wdog_q, wdog_d;
`else
    wire  [31:0]         unused_timeout = 32'(TIMEOUT);
`endif

    assign beat_addr_c = stats_in_data[ADDR_W+VAL_W-1:VAL_W];
    assign beat_val_c  = stats_in_data[VAL_W-1:0];
    assign accept_c    = stats_in_valid & ready_q;
    assign restart_c   = accept_c & (state_q == S_FRAME) & stats_in_sop;
    assign stray_c     = accept_c & (state_q == S_IDLE) & ~stats_in_sop;
    assign proc_c      = accept_c & ~stray_c;
    assign commit_c    = proc_c & stats_in_eop;
    assign addr_ok_c   = ({1'b0, beat_addr_c} < NUM_REGS_A);

    // Frame decode: an abort clears dirty before the restarting beat is written, commit sees the eop write.
    always_comb begin : next_state
        state_d   = state_q;
        ready_d   = 1'b1;
        shadow_d  = shadow_q;
        live_d    = live_q;
        dirty_d   = dirty_q;
        drop_inc  = 2'd0;
        frame_inc = 1'b0;
`ifdef STATS_COLLECTOR_TIMEOUT_EN
        wdog_d    = '0;
`endif

        if (restart_c) begin
            dirty_d  = '0;
            drop_inc = drop_inc + 2'd1;
        end
        if (stray_c) begin
            drop_inc = drop_inc + 2'd1;
        end
        if (proc_c) begin
            if (addr_ok_c) begin
                shadow_d[beat_addr_c[IDX_W-1:0]] = beat_val_c;
                dirty_d[beat_addr_c[IDX_W-1:0]]  = 1'b1;
            end else if (beat_addr_c != NOTUSED_ADDR) begin
                drop_inc = drop_inc + 2'd1;
            end
            state_d = stats_in_eop ? S_IDLE : S_FRAME;
        end
        if (commit_c) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (dirty_d[i]) begin
                    live_d[i] = shadow_d[i];
                end
            end
            dirty_d   = '0;
            frame_inc = 1'b1;
        end

`ifdef STATS_COLLECTOR_TIMEOUT_EN
        // Watchdog only advances on idle FRAME cycles; an accepted beat always wins over expiry.
        if ((state_q == S_FRAME) && !accept_c) begin
            wdog_d = wdog_q + 32'd1;
            if (wdog_d >= 32'(TIMEOUT)) begin
                dirty_d  = '0;
                drop_inc = drop_inc + 2'd1;
                state_d  = S_IDLE;
                wdog_d   = '0;
            end
        end
`endif

        frame_cnt_d = (frame_inc && (frame_cnt_q != '1)) ? frame_cnt_q + 32'd1 : frame_cnt_q;
        drop_sum    = {1'b0, drop_cnt_q} + 33'(drop_inc);
        drop_cnt_d  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // Host reads see live_q, so a read colliding with a commit returns the pre-commit value.
    always_comb begin : read_path
        rdvalid_d = csr_read;
        rddata_d  = '0;
        if (csr_read && ({1'b0, csr_addr} < NUM_REGS_A)) begin
            rddata_d = live_q[csr_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            rddata_q    <= '0;
            rdvalid_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            live_q      <= '{default: '0};
            shadow_q    <= '{default: '0};
            dirty_q     <= '0;
`ifdef STATS_COLLECTOR_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rddata_q    <= rddata_d;
            rdvalid_q   <= rdvalid_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            live_q      <= live_d;
            shadow_q    <= shadow_d;
            dirty_q     <= dirty_d;
`ifdef STATS_COLLECTOR_TIMEOUT_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign stats_in_ready    = ready_q;
    assign csr_readdata      = rddata_q;
    assign csr_readdatavalid = rdvalid_q;
    assign frame_cnt         = frame_cnt_q;
    assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_stats_collector_avlstrm.sv
// Scoreboarded bench for stats_collector_avlstrm: directed scenarios plus random traffic against a frame-replay model.
module tb_stats_collector_avlstrm;

    localparam int unsigned NR = 64;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [39:0] stats_in_data = '0;
    logic        stats_in_valid = 1'b0;
    logic        stats_in_sop = 1'b0;
    logic        stats_in_eop = 1'b0;
    logic        stats_in_ready;
    logic        csr_read = 1'b0;
    logic [7:0]  csr_addr = '0;
    logic [31:0] csr_readdata;
    logic        csr_readdatavalid;
    logic [31:0] frame_cnt;
    logic [31:0] drop_cnt;

    always #5 Clk = ~Clk;

    stats_collector_avlstrm #(
        .NUM_REGS(64), .ADDR_W(8), .VAL_W(32), .NOTUSED_ADDR(8'hFF), .TIMEOUT(1024)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .stats_in_data(stats_in_data), .stats_in_valid(stats_in_valid),
        .stats_in_sop(stats_in_sop), .stats_in_eop(stats_in_eop),
        .stats_in_ready(stats_in_ready),
        .csr_read(csr_read), .csr_addr(csr_addr),
        .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is an ordered list of writes replayed onto live at eop.
    typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t         pend[$];
    int unsigned live_m[NR];
    bit          in_frame = 1'b0;
    int unsigned frame_m = 0;
    int unsigned drop_m  = 0;
    int unsigned exp_q[$];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_read(input int unsigned a);
        return (a < NR) ? live_m[a] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) live_m[i] = 0;
        pend.delete();
        in_frame = 1'b0;
        frame_m  = 0;
        drop_m   = 0;
    endtask

    task automatic model_beat(input bit s, input bit e, input int unsigned a, input int unsigned d);
        wr_t w;
        if (!in_frame && !s) begin
            drop_m++;
            return;
        end
        if (in_frame && s) begin
            drop_m++;
            pend.delete();
        end
        in_frame = 1'b1;
        if (a < NR) begin
            w.a = 8'(a);
            w.d = d;
            pend.push_back(w);
        end else if (a != 255) begin
            drop_m++;
        end
        if (e) begin
            foreach (pend[k]) live_m[pend[k].a] = pend[k].d;
            pend.delete();
            frame_m++;
            in_frame = 1'b0;
        end
    endtask

    // Monitor: every read must answer exactly one cycle later with the scoreboarded value.
    always @(posedge Clk) begin
        int unsigned e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rd_valid", csr_readdatavalid, 1);
            if (csr_readdatavalid) chk("rd_data", csr_readdata, e);
        end else begin
            chk("rd_spurious", csr_readdatavalid, 0);
        end
    end

    // One clock of stimulus; counters are checked against the model for everything driven before.
    task automatic cyc(input bit v, input bit s, input bit e, input int unsigned a, input int unsigned d,
                       input bit rd, input int unsigned ra);
        @(negedge Clk);
        chk("frame_cnt", frame_cnt, frame_m);
        chk("drop_cnt", drop_cnt, drop_m);
        if (v) chk("ready", stats_in_ready, 1);
        if (rd) exp_q.push_back(model_read(ra));
        stats_in_valid = v;
        stats_in_sop   = s;
        stats_in_eop   = e;
        stats_in_data  = {8'(a), 32'(d)};
        csr_read       = rd;
        csr_addr       = 8'(ra);
        if (v) model_beat(s, e, a, d);
    endtask

    task automatic beat(input bit s, input bit e, input int unsigned a, input int unsigned d);
        cyc(1'b1, s, e, a, d, 1'b0, 0);
    endtask

    task automatic rd(input int unsigned a);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, a);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    function automatic int unsigned rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 7) return $urandom_range(0, NR - 1);
        if (r == 7) return 255;
        return $urandom_range(NR, 254);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_ready", stats_in_ready, 0);
        chk("rst_rdvalid", csr_readdatavalid, 0);
        chk("rst_rddata", csr_readdata, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        Rst = 1'b0;
        @(negedge Clk);
        chk("ready_after_rst", stats_in_ready, 1);

        // Basic frame
        beat(1, 0, 2, 32'h11);
        beat(0, 0, 5, 32'h22);
        beat(0, 1, 7, 32'h33);
        rd(2); rd(5); rd(7); rd(3); rd(255);

        // Atomicity: open frame must not disturb live
        beat(1, 0, 2, 32'hAA);
        repeat (10) rd(2);
        beat(0, 1, 5, 32'hBB);
        rd(2); rd(5); rd(7);

        // Stray beat, unused and out-of-range addresses
        beat(0, 0, 9, 32'h1);
        beat(1, 0, 255, 32'hDEAD);
        beat(0, 0, 100, 32'hBEEF);
        beat(0, 1, 10, 32'h10);
        rd(10); rd(100); rd(63);

        // Restart: abort then single-beat frame
        beat(1, 0, 1, 32'h5);
        beat(1, 1, 1, 32'h9);
        rd(1);

        // Restart combined with a bad address on the restarting beat
        beat(1, 0, 20, 32'h20);
        beat(1, 0, 200, 32'h0);
        beat(0, 1, 21, 32'h21);
        rd(20); rd(21);

        // Read in the same cycle as a commit returns the old value
        beat(1, 0, 6, 32'h66);
        cyc(1, 0, 1, 4, 32'h77, 1, 4);
        rd(4); rd(6);

        // Overwrite within a frame, last write wins
        beat(1, 0, 30, 32'h1);
        beat(0, 0, 30, 32'h2);
        beat(0, 1, 30, 32'h3);
        rd(30);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            bit v  = ($urandom_range(0, 1) == 1);
            bit s  = ($urandom_range(0, 9) < 3);
            bit e  = ($urandom_range(0, 9) < 3);
            bit r  = ($urandom_range(0, 1) == 1);
            cyc(v, s, e, rand_addr(), $urandom, r, $urandom_range(0, 80));
        end
        for (int i = 0; i < int'(NR); i++) rd(i);

        // Reset in the middle of a frame
        beat(1, 0, 3, 32'h1234);
        beat(0, 0, 4, 32'h5678);
        @(negedge Clk);
        Rst = 1'b1;
        stats_in_valid = 1'b0;
        csr_read = 1'b0;
        @(negedge Clk);
        chk("midrst_ready", stats_in_ready, 0);
        chk("midrst_rdvalid", csr_readdatavalid, 0);
        chk("midrst_rddata", csr_readdata, 0);
        chk("midrst_frame", frame_cnt, 0);
        chk("midrst_drop", drop_cnt, 0);
        model_reset();
        Rst = 1'b0;
        @(negedge Clk);
        chk("midrst_ready_next", stats_in_ready, 1);
        rd(2); rd(3); rd(4); rd(5);
        beat(0, 1, 4, 32'h99);
        rd(4);
        beat(1, 1, 4, 32'h42);
        rd(4);

        repeat (3) idle();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
